// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO, with RGB status LEDs.
// Define UART_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [DATA_BITS-1:0]        i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic                        o_led_r,
  output logic                        o_led_g,
  output logic                        o_led_b
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIW  = $clog2(DATA_BITS);
  localparam int SBW  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        count_s;
  logic                 ready_r;
  logic                 have_data_r;
  logic                 push_s;
  logic                 pop_s;

  state_t               state_r;
  state_t               state_s;
  logic [CNTW-1:0]      clk_cnt_r;
  logic [CNTW-1:0]      clk_cnt_s;
  logic [BIW-1:0]       bit_idx_r;
  logic [BIW-1:0]       bit_idx_s;
  logic [SBW-1:0]       stop_idx_r;
  logic [SBW-1:0]       stop_idx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 tx_r;
  logic                 tx_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 led_r_r;
  logic                 led_g_r;
  logic                 led_b_r;
  logic                 bit_done_s;
  logic                 can_start_s;
`ifdef UART_PARITY_EN
  logic                 parity_r;
`endif

  assign push_s      = i_valid && ready_r;
  assign bit_done_s  = (clk_cnt_r == CNTW'(CLKS_PER_BIT - 1));
  // have_data_r lags the count by one cycle, giving the two-edge write-to-start latency
  assign can_start_s = i_enable && have_data_r && (count_r != CW'(0));

  // Occupancy update from push/pop.
  always_comb begin
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + CW'(1);
    end else if (!push_s && pop_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge sysclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers, occupancy and ready flag.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= CW'(0);
      ready_r     <= 1'b1;
      have_data_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r     <= count_s;
      ready_r     <= (count_s < CW'(FIFO_DEPTH));
      have_data_r <= (count_r != CW'(0));
    end
  end

  // Frame sequencer: next state, bit timing and serial output.
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = clk_cnt_r + CNTW'(1);
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    shift_s    = shift_r;
    tx_s       = tx_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clk_cnt_s = CNTW'(0);
        if (can_start_s) begin
          state_s = ST_START;
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          tx_s    = 1'b0;
        end else begin
          state_s = ST_IDLE;
          tx_s    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_s   = ST_DATA;
          clk_cnt_s = CNTW'(0);
          bit_idx_s = BIW'(0);
          tx_s      = shift_r[0];
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          clk_cnt_s = CNTW'(0);
          if (bit_idx_r == BIW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_s    = ST_PARITY;
            tx_s       = parity_r;
`else
            state_s    = ST_STOP;
            stop_idx_s = SBW'(0);
            tx_s       = 1'b1;
`endif
          end else begin
            bit_idx_s = bit_idx_r + BIW'(1);
            shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
            tx_s      = shift_r[1];
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_s    = ST_STOP;
          clk_cnt_s  = CNTW'(0);
          stop_idx_s = SBW'(0);
          tx_s       = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          clk_cnt_s = CNTW'(0);
          if (stop_idx_r == SBW'(STOP_BITS - 1)) begin
            if (can_start_s) begin
              state_s = ST_START;
              pop_s   = 1'b1;
              shift_s = mem_r[rd_ptr_r];
              tx_s    = 1'b0;
            end else begin
              state_s = ST_IDLE;
              tx_s    = 1'b1;
            end
          end else begin
            stop_idx_s = stop_idx_r + SBW'(1);
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        clk_cnt_s = CNTW'(0);
        tx_s      = 1'b1;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Sequencer state and registered serial/busy outputs.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      clk_cnt_r  <= CNTW'(0);
      bit_idx_r  <= BIW'(0);
      stop_idx_r <= SBW'(0);
      shift_r    <= DATA_BITS'(0);
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
    end
  end

`ifdef UART_PARITY_EN
  // Parity of the byte being sent, captured when it leaves the FIFO.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= even_parity(mem_r[rd_ptr_r]);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Status LEDs; a frame in flight shows blue even when disabled.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      {led_r_r, led_g_r, led_b_r} <= 3'b100;
    end else if (busy_s) begin
      {led_r_r, led_g_r, led_b_r} <= 3'b001;
    end else if (!i_enable) begin
      {led_r_r, led_g_r, led_b_r} <= 3'b100;
    end else begin
      {led_r_r, led_g_r, led_b_r} <= 3'b010;
    end
  end

  assign o_ready      = ready_r;
  assign o_fifo_count = count_r;
  assign o_tx         = tx_r;
  assign o_busy       = busy_r;
  assign o_led_r      = led_r_r;
  assign o_led_g      = led_g_r;
  assign o_led_b      = led_b_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized-data bench for uart_tx_fifo; expected frames built from the byte values.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int SB    = 1;
`ifdef UART_PARITY_EN
  localparam int NBITS = 1 + DB + 1 + SB;
`else
  localparam int NBITS = 1 + DB + SB;
`endif

  logic          sysclk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [DB-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [4:0]    o_fifo_count;
  logic          o_tx;
  logic          o_busy;
  logic          o_led_r;
  logic          o_led_g;
  logic          o_led_b;
  logic [2:0]    leds;

  int errors = 0;
  int checks = 0;
  logic [DB-1:0] q[$];

  assign leds = {o_led_r, o_led_g, o_led_b};

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .STOP_BITS(SB)) dut (
    .sysclk(sysclk), .rst(rst), .i_enable(i_enable), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_fifo_count(o_fifo_count), .o_tx(o_tx), .o_busy(o_busy),
    .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line levels of one frame, index 0 = start bit.
  function automatic logic [NBITS-1:0] frame_of(input logic [DB-1:0] d);
    logic [NBITS-1:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
`ifdef UART_PARITY_EN
    f[1+DB] = ((ones % 2) == 1);
`endif
    return f;
  endfunction

  task automatic idle_checks(input string tag, input int exp_cnt, input logic [2:0] exp_leds);
    check_eq({tag, "_tx"}, 32'(o_tx), 32'd1);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_count"}, 32'(o_fifo_count), 32'(exp_cnt));
    check_eq({tag, "_leds"}, 32'(leds), 32'(exp_leds));
  endtask

  // Called on the negedge holding the first start-bit sample; returns on the negedge after the frame.
  task automatic check_frame(input logic [DB-1:0] d, input int drop_at, input int rst_at, input int exp_cnt);
    logic [NBITS-1:0] f;
    f = frame_of(d);
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        int idx;
        idx = b * CPB + c;
        check_eq("frame_tx", 32'(o_tx), 32'(f[b]));
        check_eq("frame_busy", 32'(o_busy), 32'd1);
        if (idx == 0) begin
          check_eq("frame_start_count", 32'(o_fifo_count), 32'(exp_cnt));
          check_eq("frame_start_ready", 32'(o_ready), 32'd1);
        end
        if (idx == 0 || idx == 20) check_eq("frame_led_blue", 32'(leds), 32'd1);
        if (idx == drop_at) i_enable = 1'b0;
        if (idx == rst_at) begin
          rst = 1'b1;
          #1;
          check_eq("rst_async_ready", 32'(o_ready), 32'd1);
          idle_checks("rst_async", 0, 3'b100);
          return;
        end
        @(negedge sysclk);
      end
    end
  endtask

  // Write one byte into an empty, enabled, idle transmitter and follow its frame.
  task automatic single_frame(input logic [DB-1:0] d);
    i_data = d;
    i_valid = 1'b1;
    @(negedge sysclk);
    i_valid = 1'b0;
    check_eq("wr_count", 32'(o_fifo_count), 32'd1);
    check_eq("wr_tx_edge1", 32'(o_tx), 32'd1);
    @(negedge sysclk);
    check_eq("wr_tx_edge2", 32'(o_tx), 32'd1);
    check_eq("wr_busy_edge2", 32'(o_busy), 32'd0);
    @(negedge sysclk);
    check_frame(d, -1, -1, 0);
    idle_checks("after_single", 0, 3'b010);
  endtask

  task automatic load_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      i_data = DB'($urandom);
      i_valid = 1'b1;
      q.push_back(i_data);
      @(negedge sysclk);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] singles[4];
    int n;
    rst = 1'b1;
    i_enable = 1'b0;
    i_valid = 1'b0;
    i_data = DB'(0);
    #1;
    check_eq("reset_ready", 32'(o_ready), 32'd1);
    idle_checks("reset", 0, 3'b100);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    idle_checks("post_reset", 0, 3'b100);

    // Single frames, enabled.
    i_enable = 1'b1;
    @(negedge sysclk);
    check_eq("led_green_idle", 32'(leds), 32'd2);
    singles[0] = 8'h55;
    singles[1] = 8'h07;
    singles[2] = DB'($urandom);
    singles[3] = DB'($urandom);
    for (int s = 0; s < 4; s++) single_frame(singles[s]);

    // Fill while disabled: 17 writes, the last one rejected.
    i_enable = 1'b0;
    for (int k = 0; k < 17; k++) begin
      i_data = DB'($urandom);
      i_valid = 1'b1;
      if (k < DEPTH) q.push_back(i_data);
      @(negedge sysclk);
      check_eq("fill_count", 32'(o_fifo_count), 32'((k + 1 > DEPTH) ? DEPTH : k + 1));
      check_eq("fill_ready", 32'(o_ready), 32'((k + 1) < DEPTH));
      check_eq("fill_tx", 32'(o_tx), 32'd1);
    end
    check_eq("full_leds_red", 32'(leds), 32'd4);
    // Enable with a write pending in the same cycle as the first pop: write must be dropped.
    i_data = DB'($urandom);
    i_enable = 1'b1;
    @(negedge sysclk);
    i_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) check_frame(q.pop_front(), -1, -1, DEPTH - 1 - k);
    idle_checks("drain_done", 0, 3'b010);

    // Back-to-back bursts: three bytes, then a random count.
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 3 : $urandom_range(2, 5);
      i_enable = 1'b0;
      load_bytes(n);
      check_eq("burst_loaded", 32'(o_fifo_count), 32'(n));
      i_enable = 1'b1;
      @(negedge sysclk);
      for (int k = 0; k < n; k++) check_frame(q.pop_front(), -1, -1, n - 1 - k);
      idle_checks("burst_done", 0, 3'b010);
    end

    // Drop enable during data bit 2: frame completes, second byte stays queued.
    i_enable = 1'b0;
    load_bytes(2);
    i_enable = 1'b1;
    @(negedge sysclk);
    check_frame(q.pop_front(), 13, -1, 1);
    idle_checks("drop_en_done", 1, 3'b100);
    repeat (10) @(negedge sysclk);
    idle_checks("drop_en_hold", 1, 3'b100);
    i_enable = 1'b1;
    @(negedge sysclk);
    check_frame(q.pop_front(), -1, -1, 0);
    idle_checks("resume_done", 0, 3'b010);

    // Reset during data bit 3 with two bytes queued.
    i_enable = 1'b0;
    load_bytes(3);
    i_enable = 1'b1;
    @(negedge sysclk);
    check_frame(q.pop_front(), -1, 17, 2);
    q.delete();
    @(negedge sysclk);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sysclk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0) check_eq("post_rst_quiet", {30'd0, o_tx, o_busy}, 32'd2);
    end
    idle_checks("post_rst", 0, 3'b010);
    single_frame(DB'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
